pipeline_hazard_ctrl: RTL and testbench

//  Sequences the decode stage. A register scoreboard blocks RAW/WAW hazards on rs1/rs2/rd and

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 36 +++
 rtl/pipeline_hazard_ctrl_if.sv | 35 +++
 rtl/pipeline_hazard_ctrl_hazard_scoreboard.sv | 66 ++++++
 rtl/pipeline_hazard_ctrl.sv | 109 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the decode hazard controller.
// RISC-V opcode helpers derive the decode control bits upstream of the controller.
package riscv_pipe_pkg;

  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = 5;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  function automatic logic op_uses_rs1(input logic [6:0] op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  // R, B and S types read rs2
  function automatic logic op_uses_rs2(input logic [6:0] op);
    return op == OP_REG || op == OP_BRANCH || op == OP_STORE;
  endfunction

  function automatic logic op_writes_rd(input logic [6:0] op);
    return !(op == OP_BRANCH || op == OP_STORE);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode / writeback / branch-resolve bundle seen by the hazard controller.
interface pipeline_hazard_ctrl_if
  import riscv_pipe_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = AW_DEF
);
  logic            dec_valid;
  logic [AW-1:0]   dec_rs1;
  logic [AW-1:0]   dec_rs2;
  logic [AW-1:0]   dec_rd;
  logic            dec_use_rs1;
  logic            dec_use_rs2;
  logic            dec_reg_write;
  logic            wb_valid;
  logic [AW-1:0]   wb_rd;
  logic            br_resolve;
  logic            br_taken;
  logic            issue;
  logic            stall;
  logic            flush;
  logic [NREG-1:0] busy_regs;

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_use_rs1, dec_use_rs2, dec_reg_write,
    output wb_valid, wb_rd, br_resolve, br_taken,
    input  issue, stall, flush, busy_regs
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rd, dec_use_rs1, dec_use_rs2, dec_reg_write,
    input  wb_valid, wb_rd, br_resolve, br_taken,
    output issue, stall, flush, busy_regs
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_scoreboard.sv
// Register scoreboard: pending bits with write-through writeback, hazard compare,
// and a one-entry last_set record used to drop the write of an issue squashed by a branch.
module hazard_scoreboard
  import riscv_pipe_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [AW-1:0]   rs1_i,
  input  logic [AW-1:0]   rs2_i,
  input  logic [AW-1:0]   rd_i,
  input  logic            use_rs1_i,
  input  logic            use_rs2_i,
  input  logic            reg_write_i,
  input  logic            wb_valid_i,
  input  logic [AW-1:0]   wb_rd_i,
  input  logic            issue_i,
  input  logic            squash_i,
  output logic            hazard_o,
  output logic [NREG-1:0] pend_o
);

  logic [NREG-1:0] pend_q, pend_d, pend_fwd;
  logic            last_vld_q, last_vld_d;
  logic [AW-1:0]   last_idx_q, last_idx_d;
  logic            wb_clr, set_en;

  assign wb_clr = wb_valid_i & (wb_rd_i != '0);
  assign set_en = issue_i & reg_write_i & (rd_i != '0);

  always_comb begin
    pend_fwd = pend_q;
    if (wb_clr) pend_fwd[wb_rd_i] = 1'b0;
    hazard_o = (use_rs1_i & pend_fwd[rs1_i]) |
               (use_rs2_i & pend_fwd[rs2_i]) |
               (reg_write_i & pend_fwd[rd_i]);
  end

  // last_set only records a set made in the same cycle the branch is taken;
  // it is consumed in the first flush cycle, when no new set can occur.
  always_comb begin
    pend_d = pend_fwd;
    if (last_vld_q) pend_d[last_idx_q] = 1'b0;
    if (set_en) pend_d[rd_i] = 1'b1;
    pend_d[0]  = 1'b0;
    last_vld_d = set_en & squash_i;
    last_idx_d = rd_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q     <= '0;
      last_vld_q <= 1'b0;
      last_idx_q <= '0;
    end else begin
      pend_q     <= pend_d;
      last_vld_q <= last_vld_d;
      last_idx_q <= last_idx_d;
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage sequencer: RUN/FLUSH FSM, flush counter and scoreboard hookup.
// Define HAZARD_STATS_EN to add saturating stall_cnt / flush_cnt outputs.
module pipeline_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int NREG         = NREG_DEF,
  parameter int AW           = AW_DEF,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
`ifdef HAZARD_STATS_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
`endif
  pipeline_hazard_ctrl_if.slave bus
);

  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       flush_q, flush_d;
  logic       br_take, hazard, issue, stall, squash;

  assign br_take = bus.br_resolve & bus.br_taken;
  assign squash  = (state_q == RUN) & br_take;

  hazard_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_sb (
    .clk_i       (clk),
    .rst_i       (rst),
    .rs1_i       (bus.dec_rs1),
    .rs2_i       (bus.dec_rs2),
    .rd_i        (bus.dec_rd),
    .use_rs1_i   (bus.dec_use_rs1),
    .use_rs2_i   (bus.dec_use_rs2),
    .reg_write_i (bus.dec_reg_write),
    .wb_valid_i  (bus.wb_valid),
    .wb_rd_i     (bus.wb_rd),
    .issue_i     (issue),
    .squash_i    (squash),
    .hazard_o    (hazard),
    .pend_o      (bus.busy_regs)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      RUN: begin
        issue = bus.dec_valid & ~hazard;
        stall = bus.dec_valid & hazard;
        if (br_take) begin
          state_d = FLUSH;
          cnt_d   = CNT_LOAD;
        end
      end
      FLUSH: begin
        if (br_take) begin
          cnt_d = CNT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
    endcase
    flush_d = (state_d == FLUSH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

  assign bus.issue = issue;
  assign bus.stall = stall;
  assign bus.flush = flush_q;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (br_take && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios then random traffic,
// expected outputs from a register-array reference model queued and checked at negedge.
module tb_pipeline_hazard_ctrl;
  import riscv_pipe_pkg::*;

  localparam int FC = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.NREG(32), .AW(5)) bus ();

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  pipeline_hazard_ctrl #(
    .NREG         (32),
    .AW           (5),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef HAZARD_STATS_EN
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
`endif
    .bus       (bus)
  );

  typedef struct {
    logic        issue;
    logic        stall;
    logic        flush;
    logic [31:0] busy;
    logic [31:0] scnt;
    logic [31:0] fcnt;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // reference model state
  bit [31:0] m_pend;
  int        m_flush_left;
  int        m_squash;
  longint    m_scnt, m_fcnt;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pend = '0; m_flush_left = 0; m_squash = -1; m_scnt = 0; m_fcnt = 0;
  endtask

  function automatic bit pend_eff(input int r);
    return r != 0 && m_pend[r] && !(bus.wb_valid && int'(bus.wb_rd) == r);
  endfunction

  task automatic begin_cycle();
    @(posedge clk);
    #1;
    rst               = 1'b0;
    bus.dec_valid     = 1'b0;
    bus.dec_rs1       = '0;
    bus.dec_rs2       = '0;
    bus.dec_rd        = '0;
    bus.dec_use_rs1   = 1'b0;
    bus.dec_use_rs2   = 1'b0;
    bus.dec_reg_write = 1'b0;
    bus.wb_valid      = 1'b0;
    bus.wb_rd         = '0;
    bus.br_resolve    = 1'b0;
    bus.br_taken      = 1'b0;
  endtask

  task automatic instr(input logic [6:0] op, input int rd, input int rs1, input int rs2);
    bus.dec_valid     = 1'b1;
    bus.dec_rd        = 5'(rd);
    bus.dec_rs1       = 5'(rs1);
    bus.dec_rs2       = 5'(rs2);
    bus.dec_use_rs1   = op_uses_rs1(op);
    bus.dec_use_rs2   = op_uses_rs2(op);
    bus.dec_reg_write = op_writes_rd(op);
  endtask

  task automatic wb(input int r);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'(r);
  endtask

  task automatic branch();
    bus.br_resolve = 1'b1;
    bus.br_taken   = 1'b1;
  endtask

  // Predict this cycle's outputs, queue them, then advance the model one clock.
  task automatic end_cycle();
    exp_t e;
    bit   hz, flushing, take, setr;
    int   rd;
    rd       = int'(bus.dec_rd);
    hz       = (bus.dec_use_rs1 && pend_eff(int'(bus.dec_rs1))) ||
               (bus.dec_use_rs2 && pend_eff(int'(bus.dec_rs2))) ||
               (bus.dec_reg_write && pend_eff(rd));
    flushing = m_flush_left > 0;
    e.flush  = flushing;
    e.issue  = !flushing && bus.dec_valid && !hz;
    e.stall  = !flushing && bus.dec_valid && hz;
    e.busy   = m_pend;
    e.scnt   = 32'(m_scnt);
    e.fcnt   = 32'(m_fcnt);
    q.push_back(e);

    if (rst) begin
      model_reset();
    end else begin
      take = bus.br_resolve && bus.br_taken;
      if (m_squash >= 0) m_pend[m_squash] = 1'b0;
      if (bus.wb_valid && bus.wb_rd != 0) m_pend[int'(bus.wb_rd)] = 1'b0;
      setr = e.issue && bus.dec_reg_write && rd != 0;
      if (setr) m_pend[rd] = 1'b1;
      m_squash = (setr && take && !flushing) ? rd : -1;
      if (e.stall && m_scnt < 64'hFFFF_FFFF) m_scnt++;
      if (take && m_fcnt < 64'hFFFF_FFFF) m_fcnt++;
      m_flush_left = take ? FC : (flushing ? m_flush_left - 1 : 0);
    end
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("issue", 32'(bus.issue), 32'(e.issue));
        check("stall", 32'(bus.stall), 32'(e.stall));
        check("flush", 32'(bus.flush), 32'(e.flush));
        check("busy_regs", bus.busy_regs, e.busy);
`ifdef HAZARD_STATS_EN
        check("stall_cnt", stall_cnt, e.scnt);
        check("flush_cnt", flush_cnt, e.fcnt);
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int ops_len;
    logic [6:0] ops[9];
    int pl[$];
    int r;
    ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG};
    ops_len = 9;

    rst = 1'b1;
    bus.dec_valid = 1'b0; bus.dec_rs1 = '0; bus.dec_rs2 = '0; bus.dec_rd = '0;
    bus.dec_use_rs1 = 1'b0; bus.dec_use_rs2 = 1'b0; bus.dec_reg_write = 1'b0;
    bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.br_resolve = 1'b0; bus.br_taken = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    // reset state, idle and valid-no-hazard
    begin_cycle(); end_cycle();
    begin_cycle(); instr(OP_REG, 0, 1, 2); bus.dec_reg_write = 1'b0; end_cycle();

    // RAW on x5
    begin_cycle(); instr(OP_IMM, 5, 1, 0); end_cycle();
    repeat (3) begin begin_cycle(); instr(OP_REG, 6, 5, 2); end_cycle(); end
    begin_cycle(); instr(OP_REG, 6, 5, 2); wb(5); end_cycle();
    begin_cycle(); wb(6); end_cycle();

    // x0 never tracked
    begin_cycle(); instr(OP_IMM, 0, 0, 0); end_cycle();
    begin_cycle(); instr(OP_REG, 0, 0, 0); end_cycle();
    begin_cycle(); instr(OP_STORE, 0, 0, 0); end_cycle();

    // taken branch with same-cycle issue writing x9
    begin_cycle(); instr(OP_IMM, 9, 1, 0); branch(); end_cycle();
    repeat (2) begin begin_cycle(); instr(OP_REG, 10, 1, 2); end_cycle(); end
    repeat (2) begin begin_cycle(); end_cycle(); end

    // same-cycle clear and set on x7, then reader stalls
    begin_cycle(); instr(OP_IMM, 7, 1, 0); end_cycle();
    begin_cycle(); instr(OP_IMM, 7, 1, 0); wb(7); end_cycle();
    repeat (2) begin begin_cycle(); instr(OP_STORE, 0, 2, 7); end_cycle(); end
    begin_cycle(); instr(OP_STORE, 0, 2, 7); wb(7); end_cycle();

    // WAW on x3
    begin_cycle(); instr(OP_LOAD, 3, 1, 0); end_cycle();
    repeat (2) begin begin_cycle(); instr(OP_IMM, 3, 1, 0); end_cycle(); end
    begin_cycle(); instr(OP_IMM, 3, 1, 0); wb(3); end_cycle();
    begin_cycle(); wb(3); end_cycle();

    // wb of non-pending and of x0
    begin_cycle(); wb(12); end_cycle();
    begin_cycle(); wb(0); end_cycle();

    // reset mid-flush
    begin_cycle(); instr(OP_IMM, 4, 1, 0); end_cycle();
    begin_cycle(); branch(); end_cycle();
    begin_cycle(); end_cycle();
    begin_cycle(); rst = 1'b1; end_cycle();
    repeat (2) begin begin_cycle(); end_cycle(); end

    // random traffic over a small register window to provoke hazards
    for (int unsigned i = 0; i < 3000; i++) begin
      begin_cycle();
      if ($urandom_range(99) < 80)
        instr(ops[$urandom_range(ops_len - 1)], int'($urandom_range(7)),
              int'($urandom_range(7)), int'($urandom_range(7)));
      if ($urandom_range(99) < 35) begin
        pl.delete();
        for (int k = 1; k < 32; k++) if (m_pend[k]) pl.push_back(k);
        r = (pl.size() > 0 && $urandom_range(3) != 0) ?
            pl[$urandom_range(pl.size() - 1)] : int'($urandom_range(7));
        wb(r);
      end
      if ($urandom_range(99) < 8) begin
        bus.br_resolve = 1'b1;
        bus.br_taken   = 1'($urandom_range(1));
      end
      if ($urandom_range(199) == 0) rst = 1'b1;
      end_cycle();
    end

    begin_cycle(); end_cycle();
    @(negedge clk);
    #1;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
